// File: rtl/k4n4_pattern_checker.sv
// K4N4 gate-block pattern checker: compares combinational and registered gate results against a model.
// Optional build macro K4N4_CHECKER_HALT_ON_ERR_EN ends a run on its first mismatching cycle.
module k4n4_pattern_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic [5:0]       comb_res,
  input  logic [5:0]       sync_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [7:0]       first_fail_idx
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // RUN   | checking one vector per cycle, vidx = 0 .. NUM_VECTORS-1
  // DONE  | run finished, results held until the next start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

`ifdef K4N4_CHECKER_HALT_ON_ERR_EN
  localparam bit HALT_ON_ERR = 1'b1;
`else
  localparam bit HALT_ON_ERR = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [7:0]       vidx_q;
  logic [5:0]       exp_q, exp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q;
  logic [7:0]       first_fail_idx_q;
  logic             busy_q, done_q, pass_q;

  logic             xor_v, and_v, or_v;
  logic             comb_bad, sync_bad, mismatch, start_run;

  always_comb begin
    xor_v     = a ^ b ^ c;
    and_v     = a & b & c;
    or_v      = a | b | c;
    exp_d     = {xor_v, ~xor_v, and_v, ~and_v, or_v, ~or_v};
    comb_bad  = (comb_res != exp_d);
    // the registered path has no valid history on the first vector of a run
    sync_bad  = (vidx_q != 8'd0) && (sync_res != exp_q);
    mismatch  = (state_q == S_RUN) && (comb_bad || sync_bad);
    start_run = start && (state_q != S_RUN);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((vidx_q == LAST_IDX) || (HALT_ON_ERR && mismatch)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    err_d = err_q;
    if (start_run) begin
      err_d = '0;
    end else if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      vidx_q           <= 8'd0;
      exp_q            <= 6'd0;
      err_q            <= '0;
      fail_valid_q     <= 1'b0;
      first_fail_idx_q <= 8'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      if (start_run) begin
        vidx_q           <= 8'd0;
        fail_valid_q     <= 1'b0;
        first_fail_idx_q <= 8'd0;
      end else if (state_q == S_RUN) begin
        vidx_q <= vidx_q + 8'd1;
        if (mismatch && !fail_valid_q) begin
          fail_valid_q     <= 1'b1;
          first_fail_idx_q <= vidx_q;
        end
      end
      busy_q <= (state_d == S_RUN);
      done_q <= (state_d == S_DONE);
      pass_q <= (state_d == S_DONE) && (err_d == '0);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_idx = first_fail_idx_q;

endmodule
